// File: rtl/boot_pkg.sv
// Shared definitions for the boot sequencer: FSM states, copy opcode, field widths.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE, PROBE, WAIT_OK, RETRY, LOAD, DONE, FAIL
  } boot_state_t;

  localparam int OPC_W_DEF  = 5;
  localparam int BASE_W_DEF = 11;
  localparam int ADDR_W_DEF = 16;
  localparam int INSTR_W_DEF = OPC_W_DEF + BASE_W_DEF + ADDR_W_DEF;

  localparam logic [OPC_W_DEF-1:0] OPC_COPY_HD = 5'b11111;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/boot_timer.sv
// WAIT_OK attempt timer: cleared on probe, counts while enabled, flags TIMEOUT-1.
module boot_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + TW'(1);
  end

  assign tc = (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer: probes modules with retries, then streams OS copy instructions.
// Optional BOOT_SEQ_MASK_EN adds modulo_mascara to exclude modules from the health check.
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int N_MOD  = 7,
  parameter int ADDR_W = 16,
  parameter int BASE_W = 11,
  parameter int OPC_W  = 5,
  parameter logic [BASE_W-1:0] SO_BASE = BASE_W'(1),
  parameter logic [ADDR_W-1:0] SO_ADDR = ADDR_W'(16'h0020),
  parameter logic [ADDR_W-1:0] SO_SIZE = ADDR_W'(16'h002A),
  parameter int CHUNK     = 16,
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [N_MOD-1:0]                sinal_ok,
`ifdef BOOT_SEQ_MASK_EN
  input  logic [N_MOD-1:0]                modulo_mascara,
`endif
  output logic [N_MOD-1:0]                sinal_teste,
  input  logic                            instr_ready,
  output logic                            instr_valid,
  output logic [OPC_W+BASE_W+ADDR_W-1:0]  instrucao_inicio,
  output logic                            sinal_mux,
  output logic [ADDR_W-1:0]               trava_pc,
  output logic                            busy,
  output logic                            boot_done,
  output logic                            boot_fail,
  output logic [N_MOD-1:0]                fail_mask
);

  localparam int NCH = ceil_div(int'(SO_SIZE), CHUNK);
  localparam int KW  = $clog2(NCH + 2);
  localparam int RW  = $clog2(MAX_RETRY + 2);
  localparam logic [OPC_W-1:0] OPC = OPC_W'(OPC_COPY_HD);

  boot_state_t       state, next;
  logic [RW-1:0]     retry_cnt;
  logic [KW-1:0]     k;
  logic [ADDR_W-1:0] addr;
  logic [N_MOD-1:0]  mask;
  logic              tc, all_ok, ok_exit, fail_exit, hs;

`ifdef BOOT_SEQ_MASK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              mask <= '0;
    else if (state == PROBE) mask <= modulo_mascara;
  end
`else
  assign mask = '0;
`endif

  boot_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state == PROBE),
    .en   (state == WAIT_OK),
    .tc   (tc)
  );

  assign all_ok    = &(sinal_ok | mask);
  assign ok_exit   = (state == WAIT_OK) && all_ok;
  assign fail_exit = (state == WAIT_OK) && !all_ok && tc && (retry_cnt == RW'(MAX_RETRY));
  assign hs        = (state == LOAD) && instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  // A clean response on the last timer cycle still wins over retry/fail.
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = PROBE;
      PROBE:   next = WAIT_OK;
      WAIT_OK: begin
        if (all_ok)  next = (NCH == 0) ? DONE : LOAD;
        else if (tc) next = (retry_cnt < RW'(MAX_RETRY)) ? RETRY : FAIL;
      end
      RETRY:   next = PROBE;
      LOAD:    if (instr_ready && k == KW'(NCH - 1)) next = DONE;
      DONE:    next = DONE;
      FAIL:    next = FAIL;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= '0;
      k         <= '0;
      addr      <= '0;
      trava_pc  <= '0;
      fail_mask <= '0;
    end else begin
      if (state == IDLE && start) retry_cnt <= '0;
      if (state == RETRY)         retry_cnt <= retry_cnt + RW'(1);
      if (ok_exit) begin
        trava_pc <= SO_SIZE;
        k        <= '0;
        addr     <= SO_ADDR;
      end
      if (hs) begin
        k    <= k + KW'(1);
        addr <= addr + ADDR_W'(CHUNK);
      end
      if (fail_exit) fail_mask <= ~(sinal_ok | mask);
    end
  end

  // Outputs decode the registered state, so reset clears them immediately.
  assign sinal_teste      = (state == PROBE || state == WAIT_OK) ? '1 : '0;
  assign instr_valid      = (state == LOAD);
  assign sinal_mux        = (state == LOAD);
  assign instrucao_inicio = (state == LOAD) ? {OPC, SO_BASE, addr} : '0;
  assign busy             = !(state == IDLE || state == DONE || state == FAIL);
  assign boot_done        = (state == DONE);
  assign boot_fail        = (state == FAIL);

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: healthy boot, retries/fail, stall, wrap, mid-load reset.
module tb_boot_sequencer;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, start_w = 1'b0, instr_ready = 1'b1;
  logic [6:0]  sinal_ok = '0, mascara = '0;
  logic [6:0]  teste, fmask, teste_w, fmask_w;
  logic        valid, mux, busy, done, fail;
  logic        valid_w, mux_w, busy_w, done_w, fail_w;
  logic [31:0] instr, instr_w;
  logic [15:0] trava, trava_w;

  int n_cmp = 0, n_bad = 0;
  logic [31:0] got[$];

  always #5 clk = ~clk;

  boot_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sinal_ok(sinal_ok),
`ifdef BOOT_SEQ_MASK_EN
    .modulo_mascara(mascara),
`endif
    .sinal_teste(teste), .instr_ready(instr_ready), .instr_valid(valid),
    .instrucao_inicio(instr), .sinal_mux(mux), .trava_pc(trava), .busy(busy),
    .boot_done(done), .boot_fail(fail), .fail_mask(fmask)
  );

  boot_sequencer #(.SO_ADDR(16'hFFF0), .SO_SIZE(16'd32)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start_w), .sinal_ok(sinal_ok),
`ifdef BOOT_SEQ_MASK_EN
    .modulo_mascara(mascara),
`endif
    .sinal_teste(teste_w), .instr_ready(instr_ready), .instr_valid(valid_w),
    .instrucao_inicio(instr_w), .sinal_mux(mux_w), .trava_pc(trava_w), .busy(busy_w),
    .boot_done(done_w), .boot_fail(fail_w), .fail_mask(fmask_w)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; start_w = 1'b0; sinal_ok = '0; mascara = '0; instr_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Drives instr_ready (optionally holding it low stall_len cycles before handshake
  // number stall_at) and records every accepted instruction until boot_done.
  task automatic collect(input int stall_at, input int stall_len,
                         output int stalled, output int held_bad);
    logic [31:0] held;
    held = '0; stalled = 0; held_bad = 0;
    got.delete();
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      instr_ready = !(got.size() == stall_at && stalled < stall_len);
      #1;
      if (valid && !instr_ready) begin
        if (stalled == 0) held = instr;
        else if (instr !== held) held_bad++;
        stalled++;
      end
      if (valid && instr_ready) got.push_back(instr);
    end
    instr_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if ({teste, valid, mux, busy, done, fail, fmask} !== '0) begin
      n_bad++; $display("FAIL reset_ctrl: got %h expected 0", {teste, valid, mux, busy, done, fail, fmask});
    end
    n_cmp++;
    if ({instr, trava} !== '0) begin
      n_bad++; $display("FAIL reset_data: got %h expected 0", {instr, trava});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({busy, teste} !== '0) begin
      n_bad++; $display("FAIL idle_no_start: got %h expected 0", {busy, teste});
    end
  endtask

  task automatic test_boot_ok();
    logic [31:0] exp [3] = '{32'hF801_0020, 32'hF801_0030, 32'hF801_0040};
    int st, hb;
    do_reset();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    n_cmp++;
    if ({teste, busy} !== 8'hFF) begin
      n_bad++; $display("FAIL probe_teste: got %h expected ff", {teste, busy});
    end
    @(negedge clk); #1;
    n_cmp++;
    if (teste !== 7'h7F) begin
      n_bad++; $display("FAIL wait_teste: got %h expected 7f", teste);
    end
    sinal_ok = 7'h7F;
    collect(99, 0, st, hb);
    n_cmp++;
    if (got.size() !== 3) begin
      n_bad++; $display("FAIL boot_count: got %0d expected 3", got.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        n_bad++; $display("FAIL boot_instr%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 32'h0, exp[i]);
      end
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({done, fail, busy, valid, mux, teste, trava} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 16'h002A}) begin
      n_bad++; $display("FAIL done_state: got %h expected %h", {done, fail, busy, valid, mux, teste, trava},
                        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 16'h002A});
    end
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0; #1;
    n_cmp++;
    if ({done, busy, trava} !== {1'b1, 1'b0, 16'h002A}) begin
      n_bad++; $display("FAIL done_sticky: got %h expected %h", {done, busy, trava}, {1'b1, 1'b0, 16'h002A});
    end
  endtask

  task automatic test_fail();
    int ones, gaps;
    ones = 0; gaps = 0;
    do_reset();
    sinal_ok = 7'b1110111;
    @(negedge clk); start = 1'b1;
    for (int c = 0; c < 200 && !fail; c++) begin
      @(negedge clk); start = 1'b0; #1;
      if (teste === 7'h7F) ones++;
      else if (busy) gaps++;
    end
    n_cmp++;
    if (ones !== 51) begin
      n_bad++; $display("FAIL fail_probe_cycles: got %0d expected 51", ones);
    end
    n_cmp++;
    if (gaps !== 2) begin
      n_bad++; $display("FAIL fail_retry_gaps: got %0d expected 2", gaps);
    end
    n_cmp++;
    if ({fail, done, busy, valid, fmask} !== {1'b1, 1'b0, 1'b0, 1'b0, 7'b0001000}) begin
      n_bad++; $display("FAIL fail_state: got %h expected %h", {fail, done, busy, valid, fmask},
                        {1'b1, 1'b0, 1'b0, 1'b0, 7'b0001000});
    end
    sinal_ok = 7'h7F; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0; #1;
    n_cmp++;
    if ({fail, done, fmask} !== {1'b1, 1'b0, 7'b0001000}) begin
      n_bad++; $display("FAIL fail_sticky: got %h expected %h", {fail, done, fmask}, {1'b1, 1'b0, 7'b0001000});
    end
  endtask

  task automatic test_late_ok();
    do_reset();
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 15) sinal_ok = 7'h7F;
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({valid, mux, teste, instr} !== {1'b1, 1'b1, 7'h00, 32'hF801_0020}) begin
      n_bad++; $display("FAIL late_ok_load: got %h expected %h", {valid, mux, teste, instr},
                        {1'b1, 1'b1, 7'h00, 32'hF801_0020});
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp [3] = '{32'hF801_0020, 32'hF801_0030, 32'hF801_0040};
    int st, hb;
    do_reset();
    sinal_ok = 7'h7F;
    pulse_start();
    collect(1, 5, st, hb);
    n_cmp++;
    if ({st, hb} !== {32'd5, 32'd0}) begin
      n_bad++; $display("FAIL stall_hold: got stalled=%0d unstable=%0d expected 5 and 0", st, hb);
    end
    n_cmp++;
    if (got.size() !== 3) begin
      n_bad++; $display("FAIL stall_count: got %0d expected 3", got.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        n_bad++; $display("FAIL stall_instr%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 32'h0, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int hsn, st, hb;
    logic seen;
    hsn = 0; seen = 1'b0;
    do_reset();
    sinal_ok = 7'h7F;
    pulse_start();
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      instr_ready = (hsn == 0);
      #1;
      if (valid && instr_ready) hsn++;
      else if (valid && hsn == 1) seen = 1'b1;
    end
    n_cmp++;
    if ({seen, instr} !== {1'b1, 32'hF801_0030}) begin
      n_bad++; $display("FAIL mid_second: got %h expected %h", {seen, instr}, {1'b1, 32'hF801_0030});
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({valid, mux, busy, teste, instr, trava} !== '0) begin
      n_bad++; $display("FAIL mid_async_reset: got %h expected 0", {valid, mux, busy, teste, instr, trava});
    end
    @(negedge clk); rst_n = 1'b1; instr_ready = 1'b1;
    pulse_start();
    collect(99, 0, st, hb);
    n_cmp++;
    if (got.size() !== 3 || got[0] !== 32'hF801_0020 || done !== 1'b1) begin
      n_bad++; $display("FAIL reboot: got n=%0d first=%h done=%b expected n=3 first=f8010020 done=1",
                        got.size(), (got.size() > 0) ? got[0] : 32'h0, done);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    sinal_ok = 7'h7F;
    got.delete();
    @(negedge clk); start_w = 1'b1;
    @(negedge clk); start_w = 1'b0;
    for (int c = 0; c < 40 && !done_w; c++) begin
      @(negedge clk); #1;
      if (valid_w && instr_ready) got.push_back(instr_w);
    end
    n_cmp++;
    if (got.size() !== 2) begin
      n_bad++; $display("FAIL wrap_count: got %0d expected 2", got.size());
    end
    n_cmp++;
    if (got.size() < 2 || got[0] !== 32'hF801_FFF0 || got[1] !== 32'hF801_0000) begin
      n_bad++; $display("FAIL wrap_addr: got %h %h expected f801fff0 f8010000",
                        (got.size() > 0) ? got[0] : 32'h0, (got.size() > 1) ? got[1] : 32'h0);
    end
    n_cmp++;
    if ({done_w, trava_w} !== {1'b1, 16'h0020}) begin
      n_bad++; $display("FAIL wrap_done: got %h expected %h", {done_w, trava_w}, {1'b1, 16'h0020});
    end
  endtask

`ifdef BOOT_SEQ_MASK_EN
  task automatic test_mask();
    do_reset();
    mascara = 7'b0001000;
    sinal_ok = 7'b1110111;
    pulse_start();
    for (int c = 0; c < 100 && !done && !fail; c++) @(negedge clk);
    #1;
    n_cmp++;
    if ({done, fail, fmask} !== {1'b1, 1'b0, 7'h00}) begin
      n_bad++; $display("FAIL mask_boot: got %h expected %h", {done, fail, fmask}, {1'b1, 1'b0, 7'h00});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_boot_ok();
    test_fail();
    test_late_ok();
    test_stall();
    test_reset_mid();
    test_wrap();
`ifdef BOOT_SEQ_MASK_EN
    test_mask();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
